// File: rtl/pci_target_pkg.sv
// rtl/pci_target_pkg.sv - shared commands, state encoding and sizing helper for the PCI target
package pci_target_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WRITE,
    READ_TA,
    READ,
    DONE
  } state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// rtl/pci_target_mem.sv - DEPTH x 32 word buffer, active-low byte write enables, async read
module pci_target_mem
  import pci_target_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   addr,
  input  logic [3:0]                    be,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata
);

  // No reset: contents survive a bus reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && !be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pci_target_device.sv
// rtl/pci_target_device.sv - 32-bit PCI memory target with burst read/write into a word buffer
// Build option PCI_TARGET_WAIT_EN: one wait state before the first data phase of every transfer.
module pci_target_device
  import pci_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        frame,
  inout  wire  [31:0] ad,
  input  logic [3:0]  cbe,
  input  logic        enable,
  input  logic        irdy,
  output logic        trdy,
  output logic        devsel
);

  localparam int PW = ptr_width(DEPTH);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [31:0]   rdata;
  logic          hit;
  logic          is_write;
  logic          claim;
  logic          xfer;
`ifdef PCI_TARGET_WAIT_EN
  logic          write_q;
`endif

  // Window is aligned to its size, so a hit is a compare of the upper address bits.
  assign hit      = (ad[31:PW+2] == BASE_ADDR[31:PW+2]);
  assign is_write = (cbe == CMD_MEM_WRITE);
  assign claim    = hit && (is_write || (cbe == CMD_MEM_READ));
  assign xfer     = !irdy && !trdy;

  pci_target_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (CLK),
    .we    (state == WRITE && xfer),
    .addr  (ptr),
    .be    (cbe),
    .wdata (ad),
    .rdata (rdata)
  );

  assign ad = (state == READ && !enable) ? rdata : {32{1'bz}};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      trdy   <= 1'b1;
      devsel <= 1'b1;
      ptr    <= '0;
`ifdef PCI_TARGET_WAIT_EN
      write_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!frame) begin
            ptr <= ad[PW+1:2];
            if (claim) begin
              devsel <= 1'b0;
`ifdef PCI_TARGET_WAIT_EN
              write_q <= is_write;
              state   <= DECODE;
`else
              state   <= is_write ? WRITE : READ_TA;
              trdy    <= !is_write;
`endif
            end else begin
              state <= DECODE;
            end
          end
        end
        // Unclaimed transactions idle here until the master lets frame go.
        DECODE: begin
`ifdef PCI_TARGET_WAIT_EN
          if (!devsel) begin
            state <= write_q ? WRITE : READ_TA;
            trdy  <= !write_q;
          end else if (frame) begin
            state <= IDLE;
          end
`else
          if (frame) state <= IDLE;
`endif
        end
        WRITE, READ: begin
          if (xfer) begin
            ptr <= ptr + 1'b1;
            if (frame) begin
              state  <= DONE;
              trdy   <= 1'b1;
              devsel <= 1'b1;
            end
          end
        end
        READ_TA: begin
          state <= READ;
          trdy  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target_device.sv
// tb/tb_pci_target_device.sv - randomized scoreboard bench for pci_target_device
module tb_pci_target_device;

  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;
`ifdef PCI_TARGET_WAIT_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic        CLK    = 1'b0;
  logic        reset  = 1'b1;
  logic        frame  = 1'b1;
  logic [3:0]  cbe    = 4'h0;
  logic        enable = 1'b0;
  logic        irdy   = 1'b1;
  logic [31:0] ad_drv = 32'h0;
  logic        trdy;
  logic        devsel;
  tri1  [31:0] ad;

  assign ad = enable ? ad_drv : {32{1'bz}};

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wq [$];
  logic [3:0]  bq [$];

  pci_target_device #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .frame  (frame),
    .ad     (ad),
    .cbe    (cbe),
    .enable (enable),
    .irdy   (irdy),
    .trdy   (trdy),
    .devsel (devsel)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every completed read data phase must match the oldest expected word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      #4;
      if (!reset && devsel === 1'b0 && trdy === 1'b0 && irdy === 1'b0 && enable === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_beat: unexpected data %h, expected none", ad);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", ad, e);
        end
      end
    end
  end

  // One master transaction; the model decides claim, trdy timing and data from the rules.
  task automatic txn(input logic [31:0] addr, input logic [3:0] cmd, input int nph,
                     input int stall_pct, input int rst_at);
    bit claim, is_wr, last, st, stalled, fhi, done, cmpl, tr_exp;
    int ptr, k, ph, rdy_at;
    claim  = (addr >= BASE) && (addr < BASE + DEPTH*4) && (cmd == 4'b0111 || cmd == 4'b0110);
    is_wr  = (cmd == 4'b0111);
    rdy_at = (is_wr ? 1 : 2) + WS;
    ptr    = int'((addr / 4) % DEPTH);
    @(negedge CLK);
    frame = 1'b0; irdy = 1'b1; enable = 1'b1; ad_drv = addr; cbe = cmd;
    k = 0; ph = 0; stalled = 0; fhi = 0; done = 0;
    while (!done && k < 64) begin
      @(negedge CLK);
      k++;
      if (k == rst_at) begin
        reset = 1'b1; frame = 1'b1; irdy = 1'b1; enable = 1'b0;
        #1;
        chk_b("rst_devsel", devsel, 1'b1);
        chk_b("rst_trdy", trdy, 1'b1);
        chk("rst_ad", ad, RELEASED);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        wq.delete(); bq.delete();
        return;
      end
      last    = claim ? (ph == nph - 1) : (k >= nph);
      st      = !stalled && !fhi && ($urandom_range(99) < stall_pct);
      stalled = st;
      frame   = last;
      irdy    = st;
      if (last && !st) fhi = 1;
      if (is_wr) begin
        enable = 1'b1;
        ad_drv = (ph < wq.size()) ? wq[ph] : $urandom;
        cbe    = (ph < bq.size()) ? bq[ph] : 4'h0;
      end else begin
        enable = 1'b0;
        cbe    = 4'h0;
      end
      tr_exp = !(claim && k >= rdy_at);
      cmpl   = claim && !st && !tr_exp;
      if (cmpl) begin
        if (is_wr) begin
          for (int i = 0; i < 4; i++)
            if (!cbe[i]) mem_m[ptr][8*i +: 8] = ad_drv[8*i +: 8];
        end else begin
          exp_q.push_back(mem_m[ptr]);
        end
        ptr = (ptr + 1) % DEPTH;
        ph++;
      end
      #1;
      chk_b("devsel", devsel, !claim);
      chk_b("trdy", trdy, tr_exp);
      if (!is_wr && tr_exp) chk("ad_released", ad, RELEASED);
      if (last && !st && (cmpl || !claim)) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: %0d cycles without completion, expected %0d phases", k, nph);
    end
    @(negedge CLK);
    frame = 1'b1; irdy = 1'b1; enable = 1'b0; cbe = 4'h0;
    #1;
    chk_b("rel_devsel", devsel, 1'b1);
    chk_b("rel_trdy", trdy, 1'b1);
    chk("rel_ad", ad, RELEASED);
    chk("read_queue_empty", exp_q.size(), 0);
    @(negedge CLK);
    wq.delete(); bq.delete();
  endtask

  initial begin
    int          r, n;
    logic [3:0]  c;
    logic [31:0] a;
    repeat (2) @(negedge CLK);
    #1;
    chk_b("reset_devsel", devsel, 1'b1);
    chk_b("reset_trdy", trdy, 1'b1);
    chk("reset_ad", ad, RELEASED);
    @(negedge CLK);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      wq.push_back($urandom);
      bq.push_back(4'h0);
    end
    txn(BASE, 4'b0111, DEPTH, 0, 0);

    wq = '{32'h0000_0191, 32'h0000_5555, 32'h0000_5565, 32'h0000_0100, 32'h0000_4444};
    bq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    txn(BASE, 4'b0111, 5, 0, 0);

    @(negedge CLK) reset = 1'b1;
    @(negedge CLK) reset = 1'b0;
    txn(BASE, 4'b0110, 3, 0, 0);

    wq = '{32'hFFFF_FFFF}; bq = '{4'h0};
    txn(BASE, 4'b0111, 1, 0, 0);
    wq = '{32'h0000_0191}; bq = '{4'b1010};
    txn(BASE, 4'b0111, 1, 0, 0);
    txn(BASE, 4'b0110, 1, 0, 0);

    txn(BASE, 4'b0110, 5, 50, 0);

    txn(BASE + DEPTH*4, 4'b0110, 4, 0, 0);
    txn(BASE - 4, 4'b0111, 4, 0, 0);
    txn(BASE, 4'b0010, 4, 0, 0);

    txn(BASE, 4'b0110, 6, 0, 4);
    txn(BASE, 4'b0110, DEPTH + 2, 0, 0);

    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(9);
      c = (r < 4) ? 4'b0111 : (r < 8) ? 4'b0110 : 4'($urandom_range(15));
      a = ($urandom_range(7) == 0) ? BASE + DEPTH*4 + 4*$urandom_range(15)
                                   : BASE + 4*$urandom_range(DEPTH - 1);
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        wq.push_back($urandom);
        bq.push_back(4'($urandom));
      end
      txn(a, c, n, 30, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_target_device.md
Name: pci_target_device

Overview:
- 32-bit PCI bus target with a small internal word buffer.
- Decodes memory-read and memory-write commands on a multiplexed address/data bus, claims hits with devsel, and moves burst data with the trdy/irdy handshake.
- Sits on the shared PCI bus, clocked by the system clock generator (ClockGen output CLK).

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the target window (window aligned to its size).
- DEPTH, 8, number of 32-bit words in the buffer; power of two; window size = DEPTH*4 bytes.

Ports:
- CLK  input  1  bus clock; all sampling on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame  input  1  active-low FRAME#, driven by the master.
- ad  inout  32  multiplexed address/data.
- cbe  input  4  command during the address phase; active-low byte enables during data phases.
- enable  input  1  master-drives-ad indicator; 1 = master owns ad.
- irdy  input  1  active-low initiator ready.
- trdy  output  1  active-low target ready.
- devsel  output  1  active-low device select.

Behaviour:
- Reset (async, any state): trdy=1, devsel=1, ad released (high-Z), state IDLE, word pointer = 0. Buffer contents are NOT cleared; data written before reset stays readable.
- States: IDLE, DECODE, WRITE, READ_TA (turnaround), READ, DONE.
- IDLE -> DECODE: on the rising edge where frame=0, latch ad as the address and cbe as the command.
- Hit = address within [BASE_ADDR, BASE_ADDR+DEPTH*4); pointer = ad[log2(DEPTH)+1:2].
- Command 4'b0111 = memory write; 4'b0110 = memory read.
- Miss or any other command: return to IDLE when frame=1; devsel and trdy never asserted.
- Write: cycle after the address phase, devsel=0 and trdy=0.
  - On each edge with irdy=0 and trdy=0: for each byte i with cbe[i]==0, buf[ptr][8i+7:8i] <= ad[8i+7:8i]; then ptr++.
  - irdy=1 is a wait: no write, ptr holds.
- Read: cycle after the address phase is READ_TA: devsel=0, trdy=1, ad not driven.
  - Next cycle -> READ: drive ad=buf[ptr], trdy=0.
  - On each edge with irdy=0 and trdy=0: ptr++ and ad shows the new word.
  - irdy=1 holds the same data.
  - ad is driven only when state==READ and enable==0; otherwise high-Z.
- Last data phase = completed transfer (irdy=0, trdy=0) with frame=1.
  - Next cycle: DONE, with trdy=1, devsel=1, ad released.
  - Then IDLE. No new transaction is accepted until frame has been seen high.
- Pointer wraps from DEPTH-1 to 0; bursts longer than DEPTH overwrite or re-read from word 0.
- Read latency: first data valid 2 cycles after the address edge. Write: zero wait states.
- frame rising with irdy=1 (no completed phase) keeps the transaction open until irdy=0.

Optional Feature:
- Macro PCI_TARGET_WAIT_EN.
- Defined: the target inserts exactly one wait state (trdy=1) before the first data phase of every write and read; devsel timing is unchanged.
- Undefined: timing exactly as above.

Decomposition:
- Package pci_target_pkg:
  - command localparams CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111;
  - state enum;
  - DEPTH-derived pointer width function.
- One sub-module, pci_target_mem: DEPTH x 32 register file with per-byte active-low write enables, asynchronous read port, no reset.

Test Plan:
- Full write: address 0, cmd 0111; data phases with cbe=0000: 00000191, 00005555, 00005565, 00000100, 00004444; frame=1 on the last phase -> devsel/trdy low from cycle 2; buf[0..4] holds those values; devsel/trdy high after the last phase.
- Byte enables: buf[0]=FFFFFFFF, then write cbe=1010 with ad=00000191 -> buf[0]=FF00FF91.
- Read after reset: pulse reset between the write and the read, then cmd 0110 at address 0 with enable=0 -> one turnaround cycle (trdy=1, ad=Z), then ad=00000191, 00005555, 00005565 on successive irdy=0 cycles.
- Initiator wait: during a read burst, irdy=1 for one cycle -> ad holds the same word and the pointer does not advance; final phase frame=1, irdy=0 -> release next cycle.
- Miss or other command: address BASE_ADDR+DEPTH*4, or cmd 0010 -> devsel and trdy stay 1 and ad stays Z for the whole transaction.
- Reset mid-burst: assert reset during READ -> ad goes Z and trdy=devsel=1 immediately; a subsequent read still returns the stored data.
